// File: rtl/adc_energy_pkg.sv
// adc_energy_pkg: shared constants, FSM encoding and arithmetic helpers for the pulse energy accumulator
package adc_energy_pkg;

    localparam int NUM_CHANNELS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ACCUM = 2'd2,
        DRAIN = 2'd3
    } accState_t;

    function automatic int magWidth(input int adcWidth);
        return 2 * adcWidth;
    endfunction

    // adds two values and clamps at 2^width-1, flagging when the clamp was needed
    function automatic logic [63:0] satAdd(input logic [63:0] a, input logic [63:0] b, input int width, output logic sat);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << width) - 65'd1;
        sat = sum > lim;
        return sat ? lim[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/adc_pulse_energy_accum_if.sv
// adc_pulse_energy_accum_if: sample stream, window control and published results of the energy accumulator
interface adc_pulse_energy_accum_if
    import adc_energy_pkg::*;
#(
    parameter int ADC_WIDTH   = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 48,
    parameter int COUNT_WIDTH = 8
);

    logic                                       adcValid;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0]         adcsIn;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0]         adcsQIn;
    logic                                       adcUseThisSample;
    logic                                       adcExceedsThreshold;
    logic                                       adcArm;
    logic                                       adcAutoRearm;
    logic                                       adcSumValid;
    logic [NUM_CHANNELS*ACC_WIDTH-1:0]          adcSums;
    logic [COUNT_WIDTH-1:0]                     adcSampleCount;
    logic [COUNT_WIDTH-1:0]                     adcTrigCount;
    logic                                       adcOverflow;
    logic                                       adcBusy;
    logic [NUM_CHANNELS*magWidth(ADC_WIDTH)-1:0] adcPeaks;

    modport master (
        output adcValid, adcsIn, adcsQIn, adcUseThisSample, adcExceedsThreshold, adcArm, adcAutoRearm,
        input  adcSumValid, adcSums, adcSampleCount, adcTrigCount, adcOverflow, adcBusy, adcPeaks
    );

    modport slave (
        input  adcValid, adcsIn, adcsQIn, adcUseThisSample, adcExceedsThreshold, adcArm, adcAutoRearm,
        output adcSumValid, adcSums, adcSampleCount, adcTrigCount, adcOverflow, adcBusy, adcPeaks
    );

endinterface

// File: rtl/adc_iq_power_sq.sv
// adc_iq_power_sq: one channel's two-register I^2+Q^2 pipe (square, then sum)
module adc_iq_power_sq
    import adc_energy_pkg::*;
#(
    parameter int ADC_WIDTH  = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                              adcClk,
    input  logic                              adcReset,
    input  logic [DATA_WIDTH-1:0]             iIn,
    input  logic [DATA_WIDTH-1:0]             qIn,
    output logic [magWidth(ADC_WIDTH)-1:0]    magOut
);

    localparam int MAG_WIDTH = magWidth(ADC_WIDTH);
    localparam int SQ_WIDTH  = MAG_WIDTH - 1;

    logic signed [SQ_WIDTH-1:0] iExt;
    logic signed [SQ_WIDTH-1:0] qExt;
    logic        [SQ_WIDTH-1:0] iSq;
    logic        [SQ_WIDTH-1:0] qSq;

    // sample is the MSB-aligned ADC field; widening first keeps the full-scale negative square exact
    assign iExt = SQ_WIDTH'($signed(iIn[DATA_WIDTH-1 -: ADC_WIDTH]));
    assign qExt = SQ_WIDTH'($signed(qIn[DATA_WIDTH-1 -: ADC_WIDTH]));

    // P1 squares each component, P2 sums them into the channel magnitude
    always_ff @(posedge adcClk or posedge adcReset) begin
        if (adcReset) begin
            iSq    <= '0;
            qSq    <= '0;
            magOut <= '0;
        end else begin
            iSq    <= iExt * iExt;
            qSq    <= qExt * qExt;
            magOut <= MAG_WIDTH'(iSq) + MAG_WIDTH'(qSq);
        end
    end

endmodule

// File: rtl/adc_pulse_energy_accum.sv
// adc_pulse_energy_accum: per-channel I^2+Q^2 window accumulator; ADC_PULSE_PEAK_HOLD_EN adds per-channel peak hold
module adc_pulse_energy_accum
    import adc_energy_pkg::*;
#(
    parameter int ADC_WIDTH   = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 48,
    parameter int COUNT_WIDTH = 8
) (
    input logic                    adcClk,
    input logic                    adcReset,
    adc_pulse_energy_accum_if.slave bus
);

    localparam int MAG_WIDTH = magWidth(ADC_WIDTH);

    logic                    p1Valid, p1Use, p1Trig;
    logic                    p2Valid, p2Use, p2Trig;
    logic [MAG_WIDTH-1:0]    mag     [NUM_CHANNELS];
    logic [ACC_WIDTH-1:0]    acc     [NUM_CHANNELS];
    logic [ACC_WIDTH-1:0]    accNext [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] accSat;
    logic [COUNT_WIDTH-1:0]  sampleCnt;
    logic [COUNT_WIDTH-1:0]  trigCnt;
    logic                    overflow;
    accState_t               state;
`ifdef ADC_PULSE_PEAK_HOLD_EN
    logic [MAG_WIDTH-1:0]    peak    [NUM_CHANNELS];
`endif

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : gCh
        adc_iq_power_sq #(
            .ADC_WIDTH (ADC_WIDTH),
            .DATA_WIDTH(DATA_WIDTH)
        ) uSq (
            .adcClk  (adcClk),
            .adcReset(adcReset),
            .iIn     (bus.adcsIn[c*DATA_WIDTH +: DATA_WIDTH]),
            .qIn     (bus.adcsQIn[c*DATA_WIDTH +: DATA_WIDTH]),
            .magOut  (mag[c])
        );
    end

    // window flags ride alongside the two squaring stages so the FSM sees them with their magnitude
    always_ff @(posedge adcClk or posedge adcReset) begin
        if (adcReset)
            {p1Valid, p1Use, p1Trig, p2Valid, p2Use, p2Trig} <= '0;
        else
            {p1Valid, p1Use, p1Trig, p2Valid, p2Use, p2Trig} <=
                {bus.adcValid, bus.adcUseThisSample, bus.adcExceedsThreshold, p1Valid, p1Use, p1Trig};
    end

    // running total plus the incoming magnitude, clamped at the accumulator ceiling
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++)
            accNext[c] = ACC_WIDTH'(satAdd(64'(acc[c]), 64'(mag[c]), ACC_WIDTH, accSat[c]));
    end

    assign bus.adcBusy = (state == ACCUM) || (state == DRAIN);

    // window FSM: arm, load on first use sample, accumulate, publish once in DRAIN
    always_ff @(posedge adcClk or posedge adcReset) begin
        if (adcReset) begin
            state              <= IDLE;
            sampleCnt          <= '0;
            trigCnt            <= '0;
            overflow           <= 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) acc[c] <= '0;
            bus.adcSumValid    <= 1'b0;
            bus.adcSums        <= '0;
            bus.adcSampleCount <= '0;
            bus.adcTrigCount   <= '0;
            bus.adcOverflow    <= 1'b0;
`ifdef ADC_PULSE_PEAK_HOLD_EN
            for (int c = 0; c < NUM_CHANNELS; c++) peak[c] <= '0;
            bus.adcPeaks       <= '0;
`endif
        end else begin
            bus.adcSumValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.adcArm) state <= ARMED;
                end
                ARMED: begin
                    if (p2Valid && p2Use) begin
                        state     <= ACCUM;
                        for (int c = 0; c < NUM_CHANNELS; c++) acc[c] <= ACC_WIDTH'(mag[c]);
                        sampleCnt <= COUNT_WIDTH'(1);
                        trigCnt   <= COUNT_WIDTH'(p2Trig);
                        overflow  <= 1'b0;
`ifdef ADC_PULSE_PEAK_HOLD_EN
                        for (int c = 0; c < NUM_CHANNELS; c++) peak[c] <= mag[c];
`endif
                    end
                end
                ACCUM: begin
                    if (p2Valid && !p2Use)
                        state <= DRAIN;
                    else if (p2Valid && (&sampleCnt))
                        overflow <= 1'b1;
                    else if (p2Valid) begin
                        acc       <= accNext;
                        sampleCnt <= sampleCnt + COUNT_WIDTH'(1);
                        trigCnt   <= trigCnt + COUNT_WIDTH'(p2Trig);
                        overflow  <= overflow | (|accSat);
`ifdef ADC_PULSE_PEAK_HOLD_EN
                        for (int c = 0; c < NUM_CHANNELS; c++) if (mag[c] > peak[c]) peak[c] <= mag[c];
`endif
                    end
                end
                DRAIN: begin
                    state              <= bus.adcAutoRearm ? ARMED : IDLE;
                    bus.adcSumValid    <= 1'b1;
                    for (int c = 0; c < NUM_CHANNELS; c++) bus.adcSums[c*ACC_WIDTH +: ACC_WIDTH] <= acc[c];
                    bus.adcSampleCount <= sampleCnt;
                    bus.adcTrigCount   <= trigCnt;
                    bus.adcOverflow    <= overflow;
`ifdef ADC_PULSE_PEAK_HOLD_EN
                    for (int c = 0; c < NUM_CHANNELS; c++) bus.adcPeaks[c*MAG_WIDTH +: MAG_WIDTH] <= peak[c];
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef ADC_PULSE_PEAK_HOLD_EN
    assign bus.adcPeaks = '0;
`endif

endmodule

// File: tb/tb_adc_pulse_energy_accum.sv
// tb_adc_pulse_energy_accum: directed windows on two instances (8-bit and 4-bit counters) against a window-level energy model
module tb_adc_pulse_energy_accum;
    import adc_energy_pkg::*;

    typedef struct packed {
        logic [191:0] sums;
        logic [7:0]   cnt;
        logic [7:0]   trig;
        logic         ovf;
        logic [127:0] peaks;
        logic [31:0]  cyc;
    } res_t;

    localparam longint SUMMAX = (longint'(1) << 48) - 1;

    logic        adcClk = 1'b0;
    logic        adcReset = 1'b1;
    logic        vld = 1'b0, useS = 1'b0, trg = 1'b0, arm = 1'b0, rearm = 1'b0;
    logic [63:0] iw = '0, qw = '0;
    int          cyc = 0;
    int          nVec = 0, nFail = 0;
    int          sI[4], sQ[4];
    longint      mSum[2][4], mPeak[2][4];
    int          mCnt[2], mTrig[2];
    bit          mOvf[2];
    bit          armed = 1'b0, inWin = 1'b0;
    res_t        expA[$], expB[$];
    res_t        last[2];

    always #5 adcClk = ~adcClk;
    always @(posedge adcClk) cyc <= cyc + 1;

    adc_pulse_energy_accum_if #(.COUNT_WIDTH(8)) busA ();
    adc_pulse_energy_accum_if #(.COUNT_WIDTH(4)) busB ();

    assign busA.adcValid = vld;
    assign busA.adcsIn = iw;
    assign busA.adcsQIn = qw;
    assign busA.adcUseThisSample = useS;
    assign busA.adcExceedsThreshold = trg;
    assign busA.adcArm = arm;
    assign busA.adcAutoRearm = rearm;
    assign busB.adcValid = vld;
    assign busB.adcsIn = iw;
    assign busB.adcsQIn = qw;
    assign busB.adcUseThisSample = useS;
    assign busB.adcExceedsThreshold = trg;
    assign busB.adcArm = arm;
    assign busB.adcAutoRearm = rearm;

    adc_pulse_energy_accum #(.COUNT_WIDTH(8)) dutA (.adcClk(adcClk), .adcReset(adcReset), .bus(busA));
    adc_pulse_energy_accum #(.COUNT_WIDTH(4)) dutB (.adcClk(adcClk), .adcReset(adcReset), .bus(busB));

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint magOf(input int c);
        return longint'(sI[c]) * sI[c] + longint'(sQ[c]) * sQ[c];
    endfunction

    // window-level reference: reacts to each valid input sample in input order
    task automatic modelStep(input bit u, input bit t);
        res_t   e;
        longint s;
        if (inWin && !u) begin
            for (int w = 0; w < 2; w++) begin
                e = '0;
                for (int c = 0; c < 4; c++) begin
                    e.sums[c*48 +: 48] = mSum[w][c][47:0];
`ifdef ADC_PULSE_PEAK_HOLD_EN
                    e.peaks[c*32 +: 32] = mPeak[w][c][31:0];
`endif
                end
                e.cnt  = 8'(mCnt[w]);
                e.trig = 8'(mTrig[w]);
                e.ovf  = mOvf[w];
                e.cyc  = 32'(cyc + 4);
                if (w == 0) expA.push_back(e);
                else expB.push_back(e);
            end
            inWin = 1'b0;
            armed = rearm;
        end else if (inWin) begin
            for (int w = 0; w < 2; w++) begin
                if (mCnt[w] == ((w == 0) ? 255 : 15)) mOvf[w] = 1'b1;
                else begin
                    mCnt[w]++;
                    if (t) mTrig[w]++;
                    for (int c = 0; c < 4; c++) begin
                        s = mSum[w][c] + magOf(c);
                        if (s > SUMMAX) begin
                            s = SUMMAX;
                            mOvf[w] = 1'b1;
                        end
                        mSum[w][c] = s;
                        if (magOf(c) > mPeak[w][c]) mPeak[w][c] = magOf(c);
                    end
                end
            end
        end else if (armed && u) begin
            inWin = 1'b1;
            for (int w = 0; w < 2; w++) begin
                mCnt[w]  = 1;
                mTrig[w] = t ? 1 : 0;
                mOvf[w]  = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    mSum[w][c]  = magOf(c);
                    mPeak[w][c] = magOf(c);
                end
            end
        end
    endtask

    task automatic checkDut(input int w, input logic sv, input logic [191:0] sums, input logic [7:0] cnt,
                            input logic [7:0] trig, input logic ovf, input logic [127:0] peaks);
        res_t e;
        if (sv) begin
            if ((w == 0 && expA.size() == 0) || (w == 1 && expB.size() == 0)) begin
                nVec++;
                nFail++;
                $display("FAIL unexpected_result dut%0d: got sumValid=1, expected no result (t=%0t)", w, $time);
            end else begin
                if (w == 0) e = expA.pop_front();
                else e = expB.pop_front();
                chk($sformatf("latency%0d", w), 192'(cyc), 192'(e.cyc));
                last[w] = e;
            end
        end
        chk($sformatf("sums%0d", w), sums, last[w].sums);
        chk($sformatf("count%0d", w), 192'(cnt), 192'(last[w].cnt));
        chk($sformatf("trig%0d", w), 192'(trig), 192'(last[w].trig));
        chk($sformatf("ovf%0d", w), 192'(ovf), 192'(last[w].ovf));
        chk($sformatf("peaks%0d", w), 192'(peaks), 192'(last[w].peaks));
    endtask

    always @(negedge adcClk) begin
        if (!adcReset) begin
            checkDut(0, busA.adcSumValid, busA.adcSums, busA.adcSampleCount, busA.adcTrigCount,
                     busA.adcOverflow, busA.adcPeaks);
            checkDut(1, busB.adcSumValid, busB.adcSums, 8'(busB.adcSampleCount), 8'(busB.adcTrigCount),
                     busB.adcOverflow, busB.adcPeaks);
        end
    end

    task automatic drive(input bit v, input bit u, input bit t, input bit a);
        @(negedge adcClk);
        vld  = v;
        useS = u;
        trg  = t;
        arm  = a;
        for (int c = 0; c < 4; c++) begin
            iw[c*16 +: 16] = 16'(sI[c]);
            qw[c*16 +: 16] = 16'(sQ[c]);
        end
    endtask

    task automatic smp(input bit v, input bit u, input bit t);
        drive(v, u, t, 1'b0);
        if (v) modelStep(u, t);
    endtask

    task automatic doArm();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        if (!inWin) armed = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic setCh(input int c, input int i, input int q);
        sI[c] = i;
        sQ[c] = q;
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        while ((expA.size() + expB.size()) != 0 && n < 40) begin
            @(negedge adcClk);
            n++;
        end
        @(negedge adcClk);
        chk("wait_done", 192'(expA.size() + expB.size()), 192'(0));
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_sumvalid"}, 192'(busA.adcSumValid), 192'(0));
        chk({tag, "_sums"}, busA.adcSums, 192'(0));
        chk({tag, "_count"}, 192'(busA.adcSampleCount), 192'(0));
        chk({tag, "_trig"}, 192'(busA.adcTrigCount), 192'(0));
        chk({tag, "_ovf"}, 192'(busA.adcOverflow), 192'(0));
        chk({tag, "_busy"}, 192'(busA.adcBusy), 192'(0));
        chk({tag, "_peaks"}, 192'(busA.adcPeaks), 192'(0));
        chk({tag, "_countB"}, 192'(busB.adcSampleCount), 192'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < 4; c++) setCh(c, 0, 0);
        last[0] = '0;
        last[1] = '0;
        repeat (3) @(negedge adcClk);
        checkResetOutputs("reset");
        adcReset = 1'b0;
        idle(2);

        // window 1: ch0 I=100, ch1 (-3,4), ch3 (50,-50); trig flags 1,0,1,1
        setCh(0, 100, 0);
        setCh(1, -3, 4);
        setCh(2, 0, 0);
        setCh(3, 50, -50);
        doArm();
        smp(1, 1, 1);
        smp(1, 1, 0);
        smp(1, 1, 1);
        smp(1, 1, 1);
        smp(1, 0, 0);
        waitDone();
        chk("w1_sum_ch0", 192'(busA.adcSums[47:0]), 192'(40000));
        chk("w1_sum_ch1", 192'(busA.adcSums[95:48]), 192'(100));
        chk("w1_sum_ch3", 192'(busA.adcSums[191:144]), 192'(20000));
        chk("w1_count", 192'(busA.adcSampleCount), 192'(4));
        chk("w1_trig", 192'(busA.adcTrigCount), 192'(3));

        // window 2: full-scale negative on every input
        for (int c = 0; c < 4; c++) setCh(c, -32768, -32768);
        doArm();
        repeat (3) smp(1, 1, 0);
        smp(1, 0, 0);
        waitDone();
        chk("w2_sum_ch2", 192'(busA.adcSums[143:96]), 192'(64'd6442450944));
        chk("w2_ovf", 192'(busA.adcOverflow), 192'(0));

        // window 3: 20 samples of I=1 saturate the 4-bit counter
        for (int c = 0; c < 4; c++) setCh(c, 1, 0);
        doArm();
        for (int k = 0; k < 20; k++) smp(1, 1, (k % 3) == 0);
        smp(1, 0, 0);
        waitDone();
        chk("w3_countB", 192'(busB.adcSampleCount), 192'(15));
        chk("w3_sumB", 192'(busB.adcSums[47:0]), 192'(15));
        chk("w3_ovfB", 192'(busB.adcOverflow), 192'(1));
        chk("w3_trigB", 192'(busB.adcTrigCount), 192'(5));
        chk("w3_countA", 192'(busA.adcSampleCount), 192'(20));
        chk("w3_ovfA", 192'(busA.adcOverflow), 192'(0));

        // window 4: use held high while valid toggles
        for (int c = 0; c < 4; c++) setCh(c, 2, 1);
        doArm();
        for (int k = 0; k < 10; k++) smp((k % 2) == 0, 1, 0);
        smp(1, 0, 0);
        waitDone();
        chk("w4_count", 192'(busA.adcSampleCount), 192'(5));
        chk("w4_sum", 192'(busA.adcSums[47:0]), 192'(25));

        // reset in the middle of an accumulating window
        doArm();
        repeat (3) smp(1, 1, 1);
        idle(3);
        chk("mid_busy", 192'(busA.adcBusy), 192'(1));
        @(negedge adcClk);
        adcReset = 1'b1;
        inWin = 1'b0;
        armed = 1'b0;
        expA.delete();
        expB.delete();
        last[0] = '0;
        last[1] = '0;
        @(negedge adcClk);
        checkResetOutputs("midreset");
        adcReset = 1'b0;
        idle(2);
        for (int c = 0; c < 4; c++) setCh(c, 0, 0);
        setCh(0, 10, 10);
        doArm();
        repeat (2) smp(1, 1, 0);
        smp(1, 0, 0);
        waitDone();
        chk("post_reset_sum", 192'(busA.adcSums[47:0]), 192'(400));
        chk("post_reset_count", 192'(busA.adcSampleCount), 192'(2));

        // auto re-arm off: magnitudes 5, 90, 20 then an unarmed window
        rearm = 1'b0;
        for (int c = 0; c < 4; c++) setCh(c, 0, 0);
        doArm();
        setCh(0, 1, 2);
        smp(1, 1, 0);
        setCh(0, 9, 3);
        smp(1, 1, 0);
        setCh(0, 4, 2);
        smp(1, 1, 0);
        smp(1, 0, 0);
        waitDone();
        chk("pk_sum", 192'(busA.adcSums[47:0]), 192'(115));
`ifdef ADC_PULSE_PEAK_HOLD_EN
        chk("pk_peak", 192'(busA.adcPeaks[31:0]), 192'(90));
`else
        chk("pk_peak", 192'(busA.adcPeaks[31:0]), 192'(0));
`endif
        setCh(0, 7, 0);
        repeat (2) smp(1, 1, 0);
        smp(1, 0, 0);
        idle(10);
        chk("unarmed_sum", 192'(busA.adcSums[47:0]), 192'(115));

        // auto re-arm on: two windows after a single arm
        rearm = 1'b1;
        doArm();
        setCh(0, 2, 0);
        repeat (2) smp(1, 1, 0);
        smp(1, 0, 0);
        waitDone();
        chk("rearm_w1_sum", 192'(busA.adcSums[47:0]), 192'(8));
        idle(3);
        setCh(0, 3, 0);
        smp(1, 1, 1);
        smp(1, 0, 0);
        waitDone();
        chk("rearm_w2_sum", 192'(busA.adcSums[47:0]), 192'(9));
        chk("rearm_w2_trig", 192'(busA.adcTrigCount), 192'(1));
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
